mem_packet_ctrl: RTL and testbench
==================================

// Module: mem_packet_ctrl
// PURPOSE
//  Parametrised UART-packet memory controller: pops command packets from the RX FIFO,
//  performs full-word reads/writes on an internal `memory` instance, and streams read
//  data back through the TX FIFO. Sits between the UART RX/TX FIFOs in the lab top.
//  Generalises the 8-bit/256-entry controller to multi-byte words and addresses.
// PARAMETERS
//  FIFO_WIDTH  8     FIFO byte width; only 8 is supported
//  MEM_WIDTH   32    word width in bits; multiple of 8
//  MEM_DEPTH   1024  number of words; power of two, >= 2
//  Derived (localparam): WORD_BYTES = MEM_WIDTH/8, AW = $clog2(MEM_DEPTH),
//  ADDR_BYTES = (AW+7)/8
// PORTS
//  clk            in   1            system clock, all logic on posedge
//  rst_n          in   1            reset, asynchronous assert, active-low
//  rx_fifo_empty  in   1            RX FIFO has no data
//  rx_fifo_rd_en  out  1            RX pop request
//  din            in   FIFO_WIDTH   RX FIFO data, valid the cycle after an accepted pop
//  tx_fifo_full   in   1            TX FIFO cannot accept data
//  tx_fifo_wr_en  out  1            TX push; asserted only when !tx_fifo_full
//  dout           out  FIFO_WIDTH   TX FIFO data, valid with tx_fifo_wr_en
//  state_leds     out  8            [6:0] one-hot state, [7] sticky bad-command flag
// BEHAVIOUR
//  Packet: CMD, then ADDR_BYTES address bytes MSB first; WRITE adds WORD_BYTES data bytes MSB first.
//  CMD 8'h30 = read, 8'h31 = write; any other CMD byte is consumed and dropped.
//  Address = low AW bits of the assembled address bytes; excess upper bits ignored (wrap).
//  States: IDLE(0) FETCH_CMD(1) FETCH_ADDR(2) FETCH_DATA(3) WRITE_MEM(4) READ_MEM(5) ECHO(6).
//  Byte fetch: rx_fifo_rd_en=1 for one cycle when in a FETCH state, !rx_fifo_empty and no pop
//   pending; din captured the next cycle; min 2 cycles/byte; never pop while empty.
//  IDLE -> FETCH_CMD when !rx_fifo_empty. FETCH_CMD -> FETCH_ADDR (valid cmd) or IDLE (bad cmd,
//   sets state_leds[7]). FETCH_ADDR -> READ_MEM (read) or FETCH_DATA (write) after last addr byte.
//  FETCH_DATA -> WRITE_MEM after last data byte; WRITE_MEM: mem we = all ones one cycle -> IDLE.
//  READ_MEM: drive addr one cycle, then capture mem dout (1-cycle sync read) into shift reg -> ECHO.
//  ECHO: push WORD_BYTES bytes MSB first, one per cycle while !tx_fifo_full; stall (hold dout,
//   wr_en=0) while full; -> IDLE after last byte. Read latency: last addr byte capture ->
//   first TX push = 3 cycles with TX not full.
//  No RX pops during WRITE_MEM/READ_MEM/ECHO; next packet waits in RX FIFO.
//  Reset (rst_n=0, any time): state IDLE, rx_fifo_rd_en=0, tx_fifo_wr_en=0, dout=0,
//   state_leds=8'h01, byte counters/shift regs cleared; partial packet discarded; memory
//   contents retained. A popped byte in flight at reset is lost.
//  Sticky flag state_leds[7] clears only on reset.
// CONFIGURATION
//  MEM_PACKET_CTRL_ACK_EN defined: after WRITE_MEM push 8'h06 (ACK) to TX (waiting on full)
//   before IDLE; bad CMD pushes 8'h15 (NAK) before IDLE. Adds ACK state, state_leds[6] shared.
//  Undefined: writes and bad commands produce no TX traffic.
// TESTING (MEM_WIDTH=32, MEM_DEPTH=1024 -> ADDR_BYTES=2)
//  RX 31 00 05 DE AD BE EF, then 30 00 05 -> TX DE AD BE EF; mem[5]=32'hDEADBEEF.
//  Write 31 FC 05 11 22 33 44, read 30 00 05 -> TX 11 22 33 44 (upper addr bits ignored).
//  RX 41 then 30 00 05 -> 41 dropped, state_leds[7]=1, TX returns mem[5]; with ACK_EN TX 15 first.
//  Hold tx_fifo_full=1 for 10 cycles mid-ECHO -> no push while full, bytes resume in order, none lost.
//  RX bytes with 0-20 cycle empty gaps -> rd_en never high while empty, correct packet assembly.
//  rst_n low after 31 00 05 DE -> outputs reset async; next 30 00 05 returns old mem[5].

Source files
------------

// File: rtl/mem_packet_ctrl.sv
// UART-packet memory controller: command packets popped from the RX FIFO drive word reads/writes
// on an internal memory; read data streams back out of the TX FIFO. Define MEM_PACKET_CTRL_ACK_EN for ACK/NAK replies.

module memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [WIDTH/8-1:0]       we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes; synchronous read returns the pre-write word
    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH / 8; b++) begin
            if (we[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
        end
        dout <= mem[addr];
    end
endmodule

module mem_packet_ctrl #(
    parameter int FIFO_WIDTH = 8,
    parameter int MEM_WIDTH  = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_fifo_empty,
    output logic                  rx_fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  tx_fifo_full,
    output logic                  tx_fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic [7:0]            state_leds
);
    localparam int WORD_BYTES = MEM_WIDTH / 8;
    localparam int AW         = $clog2(MEM_DEPTH);
    localparam int ADDR_BYTES = (AW + 7) / 8;
    localparam int ADDR_W     = ADDR_BYTES * 8;
    localparam int MAX_BYTES  = (WORD_BYTES > ADDR_BYTES) ? WORD_BYTES : ADDR_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0]      LAST_ADDR = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORD_BYTES - 1);
    localparam logic [FIFO_WIDTH-1:0] CMD_READ  = FIFO_WIDTH'(8'h30);
    localparam logic [FIFO_WIDTH-1:0] CMD_WRITE = FIFO_WIDTH'(8'h31);
`ifdef MEM_PACKET_CTRL_ACK_EN
    localparam logic [FIFO_WIDTH-1:0] ACK_BYTE  = FIFO_WIDTH'(8'h06);
    localparam logic [FIFO_WIDTH-1:0] NAK_BYTE  = FIFO_WIDTH'(8'h15);
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_CMD  = 3'd1,
        FETCH_ADDR = 3'd2,
        FETCH_DATA = 3'd3,
        WRITE_MEM  = 3'd4,
        READ_MEM   = 3'd5,
        ECHO       = 3'd6
`ifdef MEM_PACKET_CTRL_ACK_EN
        , ACK      = 3'd7
`endif
    } state_t;

    state_t                 state;
    logic                   cap_pend;
    logic                   is_write;
    logic                   rd_phase;
    logic                   push_q;
    logic                   bad_cmd;
    logic [CNT_W-1:0]       byte_cnt;
    logic [ADDR_W-1:0]      addr_sh;
    logic [MEM_WIDTH-1:0]   data_sh;
    logic [MEM_WIDTH-1:0]   echo_sh;
    logic [MEM_WIDTH-1:0]   mem_rdata;
    logic [WORD_BYTES-1:0]  mem_we;
    logic                   fetching;

    function automatic logic [6:0] state_onehot(input state_t s);
        logic [6:0] oh;
        oh = 7'd1 << s;
`ifdef MEM_PACKET_CTRL_ACK_EN
        if (s == ACK) oh = 7'b100_0000;
`endif
        return oh;
    endfunction

    assign fetching      = (state == FETCH_CMD) || (state == FETCH_ADDR) || (state == FETCH_DATA);
    assign tx_fifo_wr_en = push_q && !tx_fifo_full;
    assign state_leds    = {bad_cmd, state_onehot(state)};
    assign mem_we        = (state == WRITE_MEM) ? '1 : '0;

    memory #(
        .WIDTH (MEM_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_memory (
        .clk  (clk),
        .we   (mem_we),
        .addr (addr_sh[AW-1:0]),
        .din  (data_sh),
        .dout (mem_rdata)
    );

    // A pop is issued only when nothing is in flight: rd_en cycle, then the data cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rx_fifo_rd_en <= 1'b0;
            cap_pend      <= 1'b0;
            is_write      <= 1'b0;
            rd_phase      <= 1'b0;
            push_q        <= 1'b0;
            bad_cmd       <= 1'b0;
            byte_cnt      <= '0;
            addr_sh       <= '0;
            data_sh       <= '0;
            echo_sh       <= '0;
            dout          <= '0;
        end else begin
            rx_fifo_rd_en <= fetching && !rx_fifo_rd_en && !cap_pend && !rx_fifo_empty;
            cap_pend      <= rx_fifo_rd_en;

            case (state)
                IDLE: begin
                    if (!rx_fifo_empty) begin
                        byte_cnt <= '0;
                        state    <= FETCH_CMD;
                    end
                end

                FETCH_CMD: begin
                    if (cap_pend) begin
                        if (din == CMD_READ || din == CMD_WRITE) begin
                            is_write <= (din == CMD_WRITE);
                            state    <= FETCH_ADDR;
                        end else begin
                            bad_cmd <= 1'b1;
`ifdef MEM_PACKET_CTRL_ACK_EN
                            dout    <= NAK_BYTE;
                            push_q  <= 1'b1;
                            state   <= ACK;
`else
                            state   <= IDLE;
`endif
                        end
                    end
                end

                FETCH_ADDR: begin
                    if (cap_pend) begin
                        addr_sh <= (addr_sh << 8) | ADDR_W'(din);
                        if (byte_cnt == LAST_ADDR) begin
                            byte_cnt <= '0;
                            rd_phase <= 1'b0;
                            if (is_write) state <= FETCH_DATA;
                            else          state <= READ_MEM;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end

                FETCH_DATA: begin
                    if (cap_pend) begin
                        data_sh <= (data_sh << 8) | MEM_WIDTH'(din);
                        if (byte_cnt == LAST_WORD) begin
                            byte_cnt <= '0;
                            state    <= WRITE_MEM;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end

                WRITE_MEM: begin
`ifdef MEM_PACKET_CTRL_ACK_EN
                    dout   <= ACK_BYTE;
                    push_q <= 1'b1;
                    state  <= ACK;
`else
                    state  <= IDLE;
`endif
                end

                // Phase 0 presents the address, phase 1 takes the synchronous read result
                READ_MEM: begin
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        echo_sh  <= mem_rdata;
                        byte_cnt <= '0;
                        push_q   <= 1'b0;
                        state    <= ECHO;
                    end
                end

                ECHO: begin
                    if (!push_q) begin
                        dout    <= echo_sh[MEM_WIDTH-1 -: 8];
                        echo_sh <= echo_sh << 8;
                        push_q  <= 1'b1;
                    end else if (!tx_fifo_full) begin
                        if (byte_cnt == LAST_WORD) begin
                            push_q   <= 1'b0;
                            byte_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            dout     <= echo_sh[MEM_WIDTH-1 -: 8];
                            echo_sh  <= echo_sh << 8;
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end

`ifdef MEM_PACKET_CTRL_ACK_EN
                ACK: begin
                    if (push_q && !tx_fifo_full) begin
                        push_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_packet_ctrl.sv
// Self-checking bench for mem_packet_ctrl: FIFO models on both sides, a word-level memory model,
// and per-scenario tasks comparing the TX byte stream against expected bytes.
`timescale 1ns/1ps
module tb_mem_packet_ctrl;
    localparam int MEM_WIDTH  = 32;
    localparam int MEM_DEPTH  = 1024;
    localparam int AW         = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_fifo_empty = 1'b1;
    logic       rx_fifo_rd_en;
    logic [7:0] din = 8'h00;
    logic       tx_fifo_full = 1'b0;
    logic       tx_fifo_wr_en;
    logic [7:0] dout;
    logic [7:0] state_leds;

    mem_packet_ctrl #(
        .FIFO_WIDTH (8),
        .MEM_WIDTH  (MEM_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_rd_en (rx_fifo_rd_en),
        .din           (din),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .dout          (dout),
        .state_leds    (state_leds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_viol = 0;
    int wr_viol = 0;
    int last_pop_cyc = 0;
    int gap_cnt = 0;
    int stall_cnt = 0;
    bit rand_gaps = 1'b0;
    bit rand_full = 1'b0;

    logic [7:0] rx_src[$];
    int         rx_gap[$];
    logic [7:0] rx_fifo[$];
    logic [7:0] tx_got[$];
    int         tx_cyc[$];
    logic [7:0] tx_exp[$];

    logic [31:0] model_mem [MEM_DEPTH];
    int          waddrs[$];
    bit          model_bad = 1'b0;

`ifdef MEM_PACKET_CTRL_ACK_EN
    localparam int ACK_EN = 1;
`else
    localparam int ACK_EN = 0;
`endif

    // FIFO models: full is updated first, outputs are sampled 1ns later and hold until the next posedge
    initial forever begin
        @(negedge clk);
        cyc++;
        if (stall_cnt > 0) begin
            tx_fifo_full = 1'b1;
            stall_cnt--;
        end else begin
            tx_fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        #1;
        if (tx_fifo_wr_en) begin
            if (tx_fifo_full) wr_viol++;
            tx_got.push_back(dout);
            tx_cyc.push_back(cyc);
        end
        if (rx_fifo_rd_en) begin
            if (rx_fifo.size() == 0) rd_viol++;
            else begin
                din = rx_fifo.pop_front();
                last_pop_cyc = cyc;
            end
        end
        if (gap_cnt > 0) gap_cnt--;
        else if (rx_src.size() > 0) begin
            rx_fifo.push_back(rx_src.pop_front());
            gap_cnt = rx_gap.pop_front();
        end
        rx_fifo_empty = (rx_fifo.size() == 0);
    end

    task automatic put_byte(input logic [7:0] b);
        rx_src.push_back(b);
        rx_gap.push_back(rand_gaps ? int'($urandom_range(0, 20)) : 0);
    endtask

    task automatic send_write(input logic [15:0] a, input logic [31:0] d);
        put_byte(8'h31);
        put_byte(a[15:8]);
        put_byte(a[7:0]);
        for (int i = 3; i >= 0; i--) put_byte(d[i*8 +: 8]);
        model_mem[a[AW-1:0]] = d;
        waddrs.push_back(int'(a[AW-1:0]));
        if (ACK_EN != 0) tx_exp.push_back(8'h06);
    endtask

    task automatic send_read(input logic [15:0] a);
        logic [31:0] w;
        put_byte(8'h30);
        put_byte(a[15:8]);
        put_byte(a[7:0]);
        w = model_mem[a[AW-1:0]];
        for (int i = 3; i >= 0; i--) tx_exp.push_back(w[i*8 +: 8]);
    endtask

    task automatic send_bad(input logic [7:0] c);
        put_byte(c);
        model_bad = 1'b1;
        if (ACK_EN != 0) tx_exp.push_back(8'h15);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int stable;
        stable = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (rx_src.size() == 0 && rx_fifo.size() == 0 && !rx_fifo_rd_en &&
                state_leds[6:0] == 7'h01 && tx_got.size() >= tx_exp.size()) stable++;
            else stable = 0;
            if (stable >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_tx();
        tx_got.delete();
        tx_cyc.delete();
        tx_exp.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++; if (rx_fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rx_fifo_rd_en); end
        checks++; if (tx_fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", tx_fifo_wr_en); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (state_leds !== 8'h01) begin failures++; $display("FAIL reset_leds got=%h exp=01", state_leds); end
        @(negedge clk);
        rst_n = 1'b1;
        model_bad = 1'b0;
    endtask

    task automatic test_write_read();
        bit ok;
        logic [7:0] g;
        send_write(16'h0005, 32'hDEADBEEF);
        send_read(16'h0005);
        wait_done(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL write_read_timeout got=0 exp=1"); end
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL write_read_count got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        for (int i = 0; i < tx_exp.size(); i++) begin
            g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
            checks++; if (g !== tx_exp[i]) begin failures++; $display("FAIL write_read_byte%0d got=%h exp=%h", i, g, tx_exp[i]); end
        end
        checks++; if (state_leds !== 8'h01) begin failures++; $display("FAIL write_read_leds got=%h exp=01", state_leds); end
        clear_tx();
    endtask

    task automatic test_addr_wrap();
        bit ok;
        logic [7:0] g;
        send_write(16'hFC05, 32'h11223344);
        send_read(16'h0005);
        wait_done(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL addr_wrap_timeout got=0 exp=1"); end
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL addr_wrap_count got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        for (int i = 0; i < tx_exp.size(); i++) begin
            g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
            checks++; if (g !== tx_exp[i]) begin failures++; $display("FAIL addr_wrap_byte%0d got=%h exp=%h", i, g, tx_exp[i]); end
        end
        clear_tx();
    endtask

    task automatic test_bad_cmd();
        bit ok;
        logic [7:0] g;
        send_bad(8'h41);
        send_read(16'h0005);
        wait_done(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bad_cmd_timeout got=0 exp=1"); end
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL bad_cmd_count got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        for (int i = 0; i < tx_exp.size(); i++) begin
            g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
            checks++; if (g !== tx_exp[i]) begin failures++; $display("FAIL bad_cmd_byte%0d got=%h exp=%h", i, g, tx_exp[i]); end
        end
        checks++; if (state_leds !== 8'h81) begin failures++; $display("FAIL bad_cmd_leds got=%h exp=81", state_leds); end
        clear_tx();
    endtask

    task automatic test_latency();
        bit ok;
        int lat;
        send_read(16'h0005);
        wait_done(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL latency_timeout got=0 exp=1"); end
        lat = (tx_cyc.size() > 0) ? tx_cyc[0] - last_pop_cyc : -1;
        // pop sample -> capture is 2 cycles, capture -> first push is 3
        checks++; if (lat != 5) begin failures++; $display("FAIL latency_cycles got=%0d exp=5", lat); end
        checks++; if (tx_got.size() != 4) begin failures++; $display("FAIL latency_count got=%0d exp=4", tx_got.size()); end
        clear_tx();
    endtask

    task automatic test_tx_stall();
        bit ok;
        int base;
        int span;
        logic [7:0] g;
        logic [31:0] d;
        d = $urandom;
        base = ACK_EN;
        send_write(16'h0123, d);
        send_read(16'h0123);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if (tx_got.size() >= base + 1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL stall_first_push_timeout got=0 exp=1"); end
        stall_cnt = 10;
        wait_done(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=0 exp=1"); end
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        for (int i = 0; i < tx_exp.size(); i++) begin
            g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
            checks++; if (g !== tx_exp[i]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", i, g, tx_exp[i]); end
        end
        span = (tx_cyc.size() >= base + 4) ? tx_cyc[base+3] - tx_cyc[base] : -1;
        checks++; if (span < 13) begin failures++; $display("FAIL stall_span got=%0d exp>=13", span); end
        checks++; if (wr_viol != 0) begin failures++; $display("FAIL stall_push_while_full got=%0d exp=0", wr_viol); end
        clear_tx();
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] g;
        logic [7:0] c;
        logic [15:0] a;
        int k;
        rand_gaps = 1'b1;
        rand_full = 1'b1;
        for (int p = 0; p < 30; p++) begin
            k = int'($urandom_range(0, 9));
            if (k < 4) begin
                send_write(16'($urandom), $urandom);
            end else if (k < 9) begin
                a = 16'($urandom);
                a[AW-1:0] = AW'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
                send_read(a);
            end else begin
                c = 8'($urandom);
                if (c == 8'h30 || c == 8'h31) c = 8'h7F;
                send_bad(c);
            end
        end
        wait_done(30000, ok);
        rand_gaps = 1'b0;
        rand_full = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL random_timeout got=0 exp=1"); end
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        for (int i = 0; i < tx_exp.size(); i++) begin
            g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
            checks++; if (g !== tx_exp[i]) begin failures++; $display("FAIL random_byte%0d got=%h exp=%h", i, g, tx_exp[i]); end
        end
        checks++; if (rd_viol != 0) begin failures++; $display("FAIL random_pop_while_empty got=%0d exp=0", rd_viol); end
        checks++; if (wr_viol != 0) begin failures++; $display("FAIL random_push_while_full got=%0d exp=0", wr_viol); end
        checks++; if (state_leds[7] !== model_bad) begin failures++; $display("FAIL random_bad_flag got=%b exp=%b", state_leds[7], model_bad); end
        clear_tx();
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        logic [7:0] g;
        put_byte(8'h31);
        put_byte(8'h00);
        put_byte(8'h05);
        put_byte(8'hDE);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (rx_src.size() == 0 && rx_fifo.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL midreset_drain_timeout got=0 exp=1"); end
        repeat (6) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (rx_fifo_rd_en !== 1'b0) begin failures++; $display("FAIL midreset_rd_en got=%b exp=0", rx_fifo_rd_en); end
        checks++; if (tx_fifo_wr_en !== 1'b0) begin failures++; $display("FAIL midreset_wr_en got=%b exp=0", tx_fifo_wr_en); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL midreset_dout got=%h exp=00", dout); end
        checks++; if (state_leds !== 8'h01) begin failures++; $display("FAIL midreset_leds got=%h exp=01", state_leds); end
        @(negedge clk);
        rst_n = 1'b1;
        model_bad = 1'b0;
        send_read(16'h0005);
        wait_done(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midreset_read_timeout got=0 exp=1"); end
        checks++; if (tx_got.size() != tx_exp.size()) begin failures++; $display("FAIL midreset_count got=%0d exp=%0d", tx_got.size(), tx_exp.size()); end
        for (int i = 0; i < tx_exp.size(); i++) begin
            g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
            checks++; if (g !== tx_exp[i]) begin failures++; $display("FAIL midreset_byte%0d got=%h exp=%h", i, g, tx_exp[i]); end
        end
        clear_tx();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_addr_wrap();
        test_bad_cmd();
        test_latency();
        test_tx_stall();
        test_random();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
